// File: rtl/i2s_pkg.sv
// i2s_pkg: LRCK channel encoding and frame geometry shared by the I2S transmit path.
package i2s_pkg;
    localparam logic I2S_LEFT = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;
    function automatic int frame_bits(input int slot_bits);
        return 2 * slot_bits;
    endfunction
endpackage

// File: rtl/i2s_if.sv
// i2s_if: valid/ready stereo PCM sample handshake between sample source and I2S transmitter.
interface i2s_if #(
    parameter int SAMPLE_BITS = 16
);
    logic [SAMPLE_BITS-1:0] sample_l;
    logic [SAMPLE_BITS-1:0] sample_r;
    logic sample_valid;
    logic sample_ready;
    modport master (output sample_l, sample_r, sample_valid, input sample_ready);
    modport slave (input sample_l, sample_r, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into the registered I2S bit clock plus edge strobes.
module i2s_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    output logic bclk,
    output logic rise_evt,
    output logic fall_evt
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] div_cnt;
    logic wrap;
    assign wrap = div_cnt == CW'(CLK_DIV - 1);
    // Strobes lead the bclk edge by one clk so dependent flops switch together with bclk.
    assign rise_evt = wrap & ~bclk;
    assign fall_evt = wrap & bclk;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt <= '0;
            bclk <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            bclk <= bclk ^ wrap;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter; serialises stereo PCM pairs MSB-first with the one-BCLK delay.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS = 16,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    i2s_if.slave src,
    output logic i2s_bclk,
    output logic i2s_lrck,
    output logic i2s_sdata,
    output logic underrun
);
    localparam int FB = frame_bits(SLOT_BITS);
    localparam int BW = $clog2(FB);
    if (SLOT_BITS < SAMPLE_BITS) begin : g_slot_chk
        $error("i2s_tx: SLOT_BITS must be >= SAMPLE_BITS");
    end
    if (CLK_DIV < 1) begin : g_div_chk
        $error("i2s_tx: CLK_DIV must be >= 1");
    end
    logic [SAMPLE_BITS-1:0] hold_l, hold_r;
    logic [SLOT_BITS-1:0] slot_l, slot_r;
    logic [FB-1:0] shreg;
    logic [BW-1:0] b, b_next;
    logic fall_evt, unused_rise, last, load, accept;
    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
        .clk(clk),
        .resetn(resetn),
        .bclk(i2s_bclk),
        .rise_evt(unused_rise),
        .fall_evt(fall_evt)
    );
    assign last = b == BW'(FB - 1);
    assign b_next = last ? '0 : b + 1'b1;
    assign load = fall_evt & last;
    assign accept = src.sample_valid & src.sample_ready;
    assign slot_l = SLOT_BITS'(hold_l) << (SLOT_BITS - SAMPLE_BITS);
    assign slot_r = SLOT_BITS'(hold_r) << (SLOT_BITS - SAMPLE_BITS);
    // sample_ready doubles as the holding-empty flag; a load sees only the pre-edge value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            b <= BW'(FB - 1);
            i2s_lrck <= I2S_RIGHT;
            i2s_sdata <= 1'b0;
            shreg <= '0;
            src.sample_ready <= 1'b1;
            underrun <= 1'b0;
        end else begin
            underrun <= load & src.sample_ready;
            if (fall_evt) begin
                b <= b_next;
                i2s_lrck <= b_next >= BW'(SLOT_BITS) ? I2S_RIGHT : I2S_LEFT;
                i2s_sdata <= shreg[FB-1];
                shreg <= load ? (src.sample_ready ? '0 : {slot_l, slot_r}) : shreg << 1;
            end
            if (accept) begin
                hold_l <= src.sample_l;
                hold_r <= src.sample_r;
            end
            src.sample_ready <= accept ? 1'b0 : (load ? 1'b1 : src.sample_ready);
        end
    end
endmodule
